// File: rtl/s2p_pkg.sv
// Shared types and constants for the s2p_rx serial-to-parallel receiver.
package s2p_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int S2P_WIDTH = 16;

  // Bit-counter width; never below one bit so tiny words still elaborate.
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/s2p_chan.sv
// One serial channel: MSB-first shift register plus the held parallel word.
module s2p_chan
  import s2p_pkg::*;
#(
  parameter int WIDTH = S2P_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             restart,
  input  logic             commit,
  input  logic             din,
  output logic [WIDTH-1:0] word
);

  // Only WIDTH-1 bits need storing: the LSB arrives on the commit edge itself.
  logic [WIDTH-2:0] sr;
  logic [WIDTH-1:0] nxt;

  assign nxt = {sr, din};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (restart) begin
      sr <= (WIDTH-1)'(din);
    end else if (shift_en) begin
      sr <= nxt[WIDTH-2:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
    end else if (commit) begin
      word <= nxt;
    end
  end

endmodule

// File: rtl/s2p_rx.sv
// MSDAP serial-to-parallel receiver: FRAME-aligned L/R deserializer with InReady/FrameErr strobes.
// Optional: define S2P_ZERO_DETECT_EN to enable the all-zero run detector driving ZeroFlag.
module s2p_rx
  import s2p_pkg::*;
#(
  parameter int WIDTH    = S2P_WIDTH,
  parameter int ZERO_RUN = 800
) (
  input  logic             SCLK,
  input  logic             CLR,
  input  logic             FRAME,
  input  logic             INPUTL,
  input  logic             INPUTR,
  output logic [WIDTH-1:0] PDATAL,
  output logic [WIDTH-1:0] PDATAR,
  output logic             InReady,
  output logic             FrameErr,
  output logic             ZeroFlag
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH-1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             shift_en, restart, commit, abort;

  always_ff @(posedge SCLK or posedge CLR) begin
    if (CLR) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (FRAME) begin
          state_nxt = SHIFT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      SHIFT: begin
        if (FRAME) begin
          cnt_nxt = CNT_W'(1);
        end else if (cnt == LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // FRAME always restarts a word; in SHIFT it also discards the partial one.
  always_comb begin
    restart  = 1'b0;
    shift_en = 1'b0;
    commit   = 1'b0;
    abort    = 1'b0;
    unique case (state)
      IDLE: restart = FRAME;
      SHIFT: begin
        restart  = FRAME;
        abort    = FRAME;
        shift_en = !FRAME;
        commit   = !FRAME && (cnt == LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge SCLK or posedge CLR) begin
    if (CLR) begin
      InReady  <= 1'b0;
      FrameErr <= 1'b0;
    end else begin
      InReady  <= commit;
      FrameErr <= abort;
    end
  end

  s2p_chan #(.WIDTH(WIDTH)) u_chan_l (
    .clk      (SCLK),
    .rst      (CLR),
    .shift_en (shift_en),
    .restart  (restart),
    .commit   (commit),
    .din      (INPUTL),
    .word     (PDATAL)
  );

  s2p_chan #(.WIDTH(WIDTH)) u_chan_r (
    .clk      (SCLK),
    .rst      (CLR),
    .shift_en (shift_en),
    .restart  (restart),
    .commit   (commit),
    .din      (INPUTR),
    .word     (PDATAR)
  );

`ifdef S2P_ZERO_DETECT_EN
  localparam int ZC_W = $clog2(ZERO_RUN + 1);
  localparam logic [ZC_W-1:0] ZMAX = ZC_W'(ZERO_RUN);

  // Track "any one bit seen" per pair so the zero test needs no access to the shift registers.
  logic            nz_seen, pair_zero;
  logic [ZC_W-1:0] zrun, zrun_nxt;

  assign pair_zero = !(nz_seen || INPUTL || INPUTR);

  always_comb begin
    zrun_nxt = zrun;
    if (commit) begin
      if (!pair_zero)       zrun_nxt = '0;
      else if (zrun != ZMAX) zrun_nxt = zrun + ZC_W'(1);
    end
  end

  always_ff @(posedge SCLK or posedge CLR) begin
    if (CLR) begin
      nz_seen  <= 1'b0;
      zrun     <= '0;
      ZeroFlag <= 1'b0;
    end else begin
      if (restart)       nz_seen <= INPUTL || INPUTR;
      else if (shift_en) nz_seen <= nz_seen || INPUTL || INPUTR;
      zrun     <= zrun_nxt;
      ZeroFlag <= (zrun_nxt == ZMAX);
    end
  end
`else
  assign ZeroFlag = 1'b0;
`endif

endmodule

// File: tb/tb_s2p_rx.sv
// Randomized self-checking bench for s2p_rx with a word-level scoreboard model.
module tb_s2p_rx;

  localparam int W  = 16;
  localparam int ZR = 4;
`ifdef S2P_ZERO_DETECT_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  logic         SCLK = 1'b0;
  logic         CLR, FRAME, INPUTL, INPUTR;
  logic [W-1:0] PDATAL, PDATAR;
  logic         InReady, FrameErr, ZeroFlag;

  s2p_rx #(.WIDTH(W), .ZERO_RUN(ZR)) dut (
    .SCLK     (SCLK),
    .CLR      (CLR),
    .FRAME    (FRAME),
    .INPUTL   (INPUTL),
    .INPUTR   (INPUTR),
    .PDATAL   (PDATAL),
    .PDATAR   (PDATAR),
    .InReady  (InReady),
    .FrameErr (FrameErr),
    .ZeroFlag (ZeroFlag)
  );

  always #5 SCLK = ~SCLK;

  typedef struct {
    int           at;
    logic [W-1:0] l;
    logic [W-1:0] r;
  } word_t;

  int           checks   = 0;
  int           failures = 0;
  int           cyc      = 0;
  word_t        rdy_q[$];
  int           err_q[$];
  logic [W-1:0] m_l = '0, m_r = '0;
  int           m_run = 0;
  bit           mid_word = 1'b0;
  bit           mon_en = 1'b0;
  bit           exp_rdy, exp_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  always @(posedge SCLK) cyc <= cyc + 1;

  // Scoreboard: each completed word is due at a known cycle; everything else must hold.
  always @(negedge SCLK) begin
    if (CLR) begin
      m_l   = '0;
      m_r   = '0;
      m_run = 0;
    end else if (mon_en) begin
      exp_rdy = (rdy_q.size() > 0) && (rdy_q[0].at == cyc);
      check("in_ready", 32'(InReady), 32'(exp_rdy));
      if (exp_rdy) begin
        m_l = rdy_q[0].l;
        m_r = rdy_q[0].r;
        void'(rdy_q.pop_front());
        if (ZD) m_run = (m_l == '0 && m_r == '0) ? ((m_run < ZR) ? m_run + 1 : ZR) : 0;
      end
      exp_err = (err_q.size() > 0) && (err_q[0] == cyc);
      check("frame_err", 32'(FrameErr), 32'(exp_err));
      if (exp_err) void'(err_q.pop_front());
      check("pdatal", 32'(PDATAL), 32'(m_l));
      check("pdatar", 32'(PDATAR), 32'(m_r));
      check("zero_flag", 32'(ZeroFlag), 32'(m_run == ZR));
    end
  end

  // Send the first nb bits of a pair, MSB first, FRAME on the first bit.
  task automatic send(input logic [W-1:0] l, input logic [W-1:0] r, input int nb);
    word_t w;
    int    start = 0;
    for (int i = 0; i < nb; i++) begin
      @(negedge SCLK);
      if (i == 0) begin
        start = cyc + 1;
        if (mid_word) err_q.push_back(start);
      end
      FRAME  = (i == 0);
      INPUTL = l[W-1-i];
      INPUTR = r[W-1-i];
    end
    if (nb == W) begin
      w.at = start + W - 1;
      w.l  = l;
      w.r  = r;
      rdy_q.push_back(w);
      mid_word = 1'b0;
    end else begin
      mid_word = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge SCLK);
      FRAME  = 1'b0;
      INPUTL = 1'($urandom);
      INPUTR = 1'($urandom);
    end
  endtask

  task automatic expect_zero_outputs(input string tag);
    check({tag, "_pdatal"}, 32'(PDATAL), 32'd0);
    check({tag, "_pdatar"}, 32'(PDATAR), 32'd0);
    check({tag, "_in_ready"}, 32'(InReady), 32'd0);
    check({tag, "_frame_err"}, 32'(FrameErr), 32'd0);
    check({tag, "_zero_flag"}, 32'(ZeroFlag), 32'd0);
  endtask

  initial begin
    logic [W-1:0] l, r;
    CLR = 1'b1; FRAME = 1'b0; INPUTL = 1'b0; INPUTR = 1'b0;
    #1;
    expect_zero_outputs("reset");
    repeat (3) @(negedge SCLK);
    CLR    = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // Directed: basic word, back-to-back pair, mid-word abort.
    send(16'hA5C3, 16'h1234, W);
    idle(3);
    send(16'h8000, 16'h0001, W);
    send(16'h7FFF, 16'hFFFE, W);
    idle(2);
    send(16'h5555, 16'hAAAA, 7);
    send(16'h0F0F, 16'hF0F0, W);
    idle(2);
    send(16'h1357, 16'h2468, 15);
    send(16'hC001, 16'h3FFE, W);
    idle(2);

    // CLR partway through a word: everything clears at once, no strobe follows.
    send(16'hFFFF, 16'hFFFF, 10);
    @(negedge SCLK);
    CLR = 1'b1; FRAME = 1'b0;
    mid_word = 1'b0;
    #1;
    expect_zero_outputs("midclr");
    @(negedge SCLK);
    CLR = 1'b0;
    idle(6);
    send(16'h00FF, 16'hFF00, W);
    idle(2);

    // Randomized traffic: full words, aborted partials, idle gaps with junk data.
    for (int n = 0; n < 150; n++) begin
      l = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
      r = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
      if ($urandom_range(0, 3) == 0) send(l, r, $urandom_range(1, W - 1));
      else                           send(l, r, W);
      if (!mid_word) idle($urandom_range(0, 3));
    end
    if (mid_word) send(16'h1111, 16'h2222, W);
    idle(2);

    // Zero runs: flag reaches ZR with the ZR-th pair, then a nonzero word clears it.
    repeat (ZR + 2) send('0, '0, W);
    send(16'h0001, '0, W);
    idle(2);
    repeat (1000) send('0, '0, W);
    idle(20);

    check("drain", 32'(rdy_q.size() + err_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
